// File: rtl/byte_unit_pkg.sv
// Shared constants and state encoding for the byte-serial program loader.
package byte_unit_pkg;

   localparam int INSTR_W  = 21;
   localparam int ADDR_W   = 8;
   localparam int ROM_SIZE = 256;

   localparam logic [INSTR_W-1:0] END_MARKER = 21'h1FFFFF;
   localparam logic [INSTR_W-1:0] NOP_INSTR  = 21'h00000F;

   typedef enum logic [2:0] {
      IDLE,
      BYTE0,
      BYTE1,
      BYTE2,
      WRITE,
      DONE,
      ERROR
   } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Assembles 3-byte little-endian instructions from a byte stream and writes
// them to instruction memory, holding the CPU in suspend while loading.
module program_loader #(
   parameter int ADDR_W   = byte_unit_pkg::ADDR_W,
   parameter int INSTR_W  = byte_unit_pkg::INSTR_W,
   parameter int ROM_SIZE = byte_unit_pkg::ROM_SIZE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_address,
   output logic [INSTR_W-1:0] wr_data,
   output logic               suspend_cpu,
   output logic               load_done,
   output logic               load_error,
   output logic [ADDR_W:0]    instr_count
);

   import byte_unit_pkg::*;

   localparam int HI_BITS = INSTR_W - 16;
   localparam logic [INSTR_W-1:0] MARKER    = INSTR_W'(END_MARKER);
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(ROM_SIZE - 1);

   loader_state_e      state_q, state_d;
   logic [7:0]         b0_q, b0_d;
   logic [7:0]         b1_q, b1_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic [INSTR_W-1:0] data_q, data_d;
   logic               wr_en_q, wr_en_d;
   logic               suspend_q, suspend_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               xfer;
   logic               pad_bad;

   assign byte_ready = (state_q == BYTE0) || (state_q == BYTE1) || (state_q == BYTE2);
   assign xfer       = byte_ready && byte_valid;
   assign pad_bad    = (byte_in >> HI_BITS) != 8'd0;

   // Next-state and registered-output logic; the write strobe is raised on the
   // BYTE2 transfer so it is visible for exactly the WRITE cycle.
   always_comb begin
      state_d   = state_q;
      b0_d      = b0_q;
      b1_d      = b1_q;
      addr_d    = addr_q;
      count_d   = count_q;
      data_d    = data_q;
      wr_en_d   = 1'b0;
      suspend_d = suspend_q;
      done_d    = done_q;
      error_d   = error_q;
      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (load_start) begin
               state_d   = BYTE0;
               addr_d    = '0;
               count_d   = '0;
               done_d    = 1'b0;
               error_d   = 1'b0;
               suspend_d = 1'b1;
            end
         end
         BYTE0: begin
            if (xfer) begin
               b0_d    = byte_in;
               state_d = BYTE1;
            end
         end
         BYTE1: begin
            if (xfer) begin
               b1_d    = byte_in;
               state_d = BYTE2;
            end
         end
         BYTE2: begin
            if (xfer) begin
               if (pad_bad) begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end else begin
                  data_d  = {byte_in[HI_BITS-1:0], b1_q, b0_q};
                  wr_en_d = 1'b1;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            count_d = count_q + (ADDR_W+1)'(1);
            if (data_q == MARKER) begin
               state_d   = DONE;
               done_d    = 1'b1;
               suspend_d = 1'b0;
            end else if (addr_q == LAST_ADDR) begin
               // No room left for the end marker: treat as overflow.
               state_d = ERROR;
               error_d = 1'b1;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = BYTE0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state clears on reset so every output reads zero immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         b0_q      <= '0;
         b1_q      <= '0;
         addr_q    <= '0;
         count_q   <= '0;
         data_q    <= '0;
         wr_en_q   <= 1'b0;
         suspend_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         b0_q      <= b0_d;
         b1_q      <= b1_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         data_q    <= data_d;
         wr_en_q   <= wr_en_d;
         suspend_q <= suspend_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_address  = addr_q;
   assign wr_data     = data_q;
   assign suspend_cpu = suspend_q;
   assign load_done   = done_q;
   assign load_error  = error_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a list-based
// model of which words land in memory and how the load terminates.
module tb_program_loader;

   import byte_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        loadStart = 1'b0;
   logic [7:0]  byteIn = 8'h00;
   logic        byteValid = 1'b0;
   logic        byteReady;
   logic        wrEn;
   logic [7:0]  wrAddress;
   logic [20:0] wrData;
   logic        suspendCpu;
   logic        loadDone;
   logic        loadError;
   logic [8:0]  instrCount;

   int checkCount = 0;
   int failCount  = 0;
   int cyc        = 0;
   int startCyc   = 0;
   int endCyc     = 0;
   bit stuck      = 0;

   logic [20:0] progQ[$];
   logic [7:0]  expAddr[$];
   logic [20:0] expData[$];
   logic [7:0]  gotAddr[$];
   logic [20:0] gotData[$];
   bit          expDone;
   bit          expError;

   program_loader #(.ADDR_W(8), .INSTR_W(21), .ROM_SIZE(256)) dut (
      .clk(clk), .rst(rst), .load_start(loadStart), .byte_in(byteIn),
      .byte_valid(byteValid), .byte_ready(byteReady), .wr_en(wrEn),
      .wr_address(wrAddress), .wr_data(wrData), .suspend_cpu(suspendCpu),
      .load_done(loadDone), .load_error(loadError), .instr_count(instrCount)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every write strobe seen away from the clock edge.
   always @(negedge clk) begin
      if (!rst && wrEn) begin
         gotAddr.push_back(wrAddress);
         gotData.push_back(wrData);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Words are written in order from address 0 until the marker (done) or
   // the last memory slot is used by a non-marker word (overflow).
   task automatic computeExpected();
      expAddr.delete();
      expData.delete();
      expDone  = 0;
      expError = 0;
      foreach (progQ[i]) begin
         if (expDone || expError) break;
         expAddr.push_back(8'(i));
         expData.push_back(progQ[i]);
         if (progQ[i] == 21'h1FFFFF) expDone = 1;
         else if (i == 255) expError = 1;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic sendByte(input logic [7:0] b, input bit gaps);
      bit sent = 0;
      int guard = 0;
      while (!sent && !stuck) begin
         byteIn    = b;
         byteValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         if (byteValid && byteReady) sent = 1;
         @(negedge clk);
         guard++;
         if (!sent && guard > 60) begin
            checkOutput("byte_accept_timeout", 0, 1);
            stuck = 1;
         end
      end
   endtask

   task automatic sendWord(input logic [20:0] w, input bit gaps);
      sendByte(w[7:0], gaps);
      sendByte(w[15:8], gaps);
      sendByte({3'b000, w[20:16]}, gaps);
   endtask

   task automatic pulseStart();
      @(negedge clk);
      loadStart = 1'b1;
      @(negedge clk);
      loadStart = 1'b0;
      startCyc  = cyc;
   endtask

   task automatic waitTerminal();
      int k = 0;
      while (!(loadDone || loadError) && k < 40) begin
         @(negedge clk);
         k++;
      end
      endCyc = cyc;
      if (!(loadDone || loadError)) checkOutput("terminal_timeout", 0, 1);
   endtask

   task automatic compareWrites(input string tag);
      checkOutput({tag, "_wr_count"}, gotData.size(), expData.size());
      for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), gotAddr[i], expAddr[i]);
         checkOutput($sformatf("%s_data%0d", tag, i), gotData[i], expData[i]);
      end
   endtask

   task automatic checkFinal(input string tag);
      checkOutput({tag, "_done"}, loadDone, expDone);
      checkOutput({tag, "_error"}, loadError, expError);
      checkOutput({tag, "_suspend"}, suspendCpu, expDone ? 0 : 1);
      checkOutput({tag, "_count"}, instrCount, expData.size());
      checkOutput({tag, "_ready"}, byteReady, 0);
   endtask

   // Full load of progQ; midStart pulses load_start during the BYTE1 state.
   task automatic applyStimulus(input string tag, input bit gaps, input bit midStart);
      computeExpected();
      gotAddr.delete();
      gotData.delete();
      stuck = 0;
      pulseStart();
      for (int i = 0; i < expData.size(); i++) begin
         if (midStart && i == 0) begin
            sendByte(progQ[i][7:0], gaps);
            loadStart = 1'b1;
            sendByte(progQ[i][15:8], gaps);
            loadStart = 1'b0;
            sendByte({3'b000, progQ[i][20:16]}, gaps);
         end else begin
            sendWord(progQ[i], gaps);
         end
      end
      byteValid = 1'b0;
      waitTerminal();
      compareWrites(tag);
      checkFinal(tag);
      if (!gaps && expDone)
         checkOutput({tag, "_throughput"}, (endCyc - startCyc) <= 4 * expData.size(), 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_wr_en"}, wrEn, 0);
      checkOutput({tag, "_wr_address"}, wrAddress, 0);
      checkOutput({tag, "_wr_data"}, wrData, 0);
      checkOutput({tag, "_byte_ready"}, byteReady, 0);
      checkOutput({tag, "_suspend"}, suspendCpu, 0);
      checkOutput({tag, "_done"}, loadDone, 0);
      checkOutput({tag, "_error"}, loadError, 0);
      checkOutput({tag, "_count"}, instrCount, 0);
   endtask

   initial begin
      int n;
      #1;
      checkAllZero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("idle");

      progQ = '{21'h000123, 21'h0ABCDE, 21'h1FFFFF};
      applyStimulus("basic", 0, 0);

      // Pad bits set in the third byte abort with no write.
      gotAddr.delete();
      gotData.delete();
      stuck = 0;
      pulseStart();
      sendByte(8'h23, 0);
      sendByte(8'h01, 0);
      sendByte(8'h20, 0);
      byteValid = 1'b0;
      waitTerminal();
      checkOutput("pad_error", loadError, 1);
      checkOutput("pad_done", loadDone, 0);
      checkOutput("pad_suspend", suspendCpu, 1);
      checkOutput("pad_writes", gotData.size(), 0);
      checkOutput("pad_count", instrCount, 0);

      progQ.delete();
      for (int i = 0; i < 256; i++) progQ.push_back(21'h000001);
      progQ.push_back(21'h1FFFFF);
      applyStimulus("overflow", 0, 0);

      progQ = '{21'h000123, 21'h0ABCDE, 21'h1FFFFF};
      applyStimulus("gaps", 1, 0);

      for (int r = 0; r < 4; r++) begin
         progQ.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) progQ.push_back(21'($urandom));
         progQ.push_back(21'h1FFFFF);
         applyStimulus($sformatf("rand%0d", r), r[0], 0);
      end

      // Reset in the middle of the second instruction.
      gotAddr.delete();
      gotData.delete();
      stuck = 0;
      pulseStart();
      sendWord(21'h000123, 0);
      sendByte(8'hDE, 0);
      sendByte(8'hBC, 0);
      byteValid = 1'b0;
      rst = 1'b1;
      #1;
      checkAllZero("midreset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("postreset");
      progQ = '{21'h0ABCDE, 21'h1FFFFF};
      applyStimulus("restart", 0, 0);

      progQ = '{21'h000123, 21'h0ABCDE, 21'h1FFFFF};
      applyStimulus("midstart", 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ADDR_W, 8, instruction memory address width.
REQ-002 INSTR_W, 21, instruction width.
REQ-003 ROM_SIZE, 256, instruction memory depth in words.
REQ-004 The block SHALL have these ports (name direction width meaning): clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 load_start  input  1  one-cycle request to begin a program load.
REQ-007 byte_in  input  8  serial program byte.
REQ-008 byte_valid  input  1  byte_in is valid.
REQ-009 byte_ready  output  1  block accepts byte_in this cycle.
REQ-010 wr_en  output  1  instruction memory write strobe.
REQ-011 wr_address  output  ADDR_W  instruction memory write address.
REQ-012 wr_data  output  INSTR_W  instruction memory write data.
REQ-013 suspend_cpu  output  1  holds CPU fetch while loading.
REQ-014 load_done  output  1  load completed successfully.
REQ-015 load_error  output  1  load aborted on a protocol or overflow fault.
REQ-016 instr_count  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-017 The states SHALL be IDLE, BYTE0, BYTE1, BYTE2, WRITE, DONE and ERROR.
REQ-018 A byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 only in BYTE0, BYTE1 and BYTE2.
REQ-020 load_start in IDLE, DONE or ERROR SHALL go to BYTE0 next cycle, clear the address, instr_count, load_done and load_error, and set suspend_cpu=1.
REQ-021 load_start in any other state SHALL be ignored.
REQ-022 Each instruction SHALL be three bytes, little-endian: byte0=bits[7:0], byte1=bits[15:8], byte2[4:0]=bits[20:16].
REQ-023 Each transfer SHALL advance BYTE0->BYTE1->BYTE2; BYTE2 transfer->WRITE.
REQ-024 If byte2[7:5]!=0 on the BYTE2 transfer, the block SHALL go to ERROR instead of WRITE, with no write.
REQ-025 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_address=current address and wr_data=assembled word; the strobe SHALL come one cycle after the BYTE2 transfer.
REQ-026 After WRITE, instr_count SHALL increment.
REQ-027 After WRITE, if the word equals END_MARKER (all ones), the block SHALL go to DONE; the marker itself SHALL be written.
REQ-028 Else, if the address equals ROM_SIZE-1, the block SHALL go to ERROR (overflow, no room for END_MARKER).
REQ-029 Else the address SHALL increment and the block SHALL go to BYTE0.
REQ-030 DONE SHALL drive suspend_cpu=0 and load_done=1, held until load_start or reset.
REQ-031 ERROR SHALL drive suspend_cpu=1 and load_error=1, held until load_start or reset.
REQ-032 IDLE SHALL drive suspend_cpu=0, load_done=0 and load_error=0.
REQ-033 wr_en SHALL be 0 outside WRITE; byte_valid without byte_ready SHALL have no effect.
REQ-034 Minimum throughput SHALL be one instruction per 4 cycles.

Reset
REQ-035 rst=1 SHALL force IDLE immediately, in any state including mid-load.
REQ-036 During reset all outputs SHALL be 0: wr_en, wr_address, wr_data, byte_ready, suspend_cpu, load_done, load_error, instr_count.
REQ-037 Memory contents already written SHALL not be recovered or cleared by the loader.

Structure
REQ-038 The shared package byte_unit_pkg SHALL hold INSTR_W, ADDR_W, ROM_SIZE, END_MARKER (21'h1FFFFF), NOP_INSTR (21'h00000F) and the loader state enum.
REQ-039 The block SHALL be one module, no sub-modules: a byte-assembly register plus the FSM.

Verification
REQ-040 Load 3 instructions 0x000123, 0x0ABCDE, END_MARKER with byte_valid held high -> wr_en at addresses 0,1,2 with those values; load_done=1; instr_count=3; suspend_cpu falls.
REQ-041 Bytes 0x23,0x01 then 0x20 (pad bit set) -> load_error=1, no wr_en, suspend_cpu stays 1.
REQ-042 256 non-marker words (0x000001) -> 256 writes at addresses 0..255, then ERROR; instr_count=256.
REQ-043 Random byte_valid gaps (~50%) -> the same write sequence as REQ-040; no byte lost or duplicated.
REQ-044 rst asserted after byte1 of the second instruction -> outputs 0 and IDLE at once; a new load_start restarts at address 0.
REQ-045 load_start pulsed in BYTE1 -> ignored; the load completes normally.
